// File: rtl/gpr_scoreboard_pkg.sv
// gpr_scoreboard_pkg
//   Shared types and default sizing for the GPR hazard scoreboard.
//   gpr_state_t is one-hot so the per-register status vectors fall straight
//   out of single state bits.
package gpr_scoreboard_pkg;

  localparam int DEFAULT_REGCOUNT     = 16;
  localparam int DEFAULT_ADDRWIDTH    = 4;
  localparam int DEFAULT_PENDINGWIDTH = 8;

  typedef enum logic [3:0] {
    GPR_CLEAN  = 4'b0001,
    GPR_DIRTY  = 4'b0010,
    GPR_SOILED = 4'b0100,
    GPR_PENDWR = 4'b1000
  } gpr_state_t;

endpackage

// File: rtl/gpr_state_cell.sv
// gpr_state_cell
//   Hazard FSM and pending-runahead-read counter for a single GPR.
//   Ports:
//     clk, clk_en, sync_rst  clock, global enable, synchronous reset
//     accept                 the issuing instruction is accepted this cycle
//     to_runahead            accepted instruction goes to the runahead queue
//     from_runahead          accepted instruction comes from the runahead queue
//     dirty_issue            accepted instruction is multicycle
//     rd_count               number of operands (0..2) reading this register
//     wr                     this register is the instruction's destination
//     dw                     multicycle writeback targets this register
//     state                  current FSM state
//     clamp                  counter saturated or underflowed this cycle
//   PENDINGWIDTH must be at least 2 so the counter can hold a double read.
module gpr_state_cell
  import gpr_scoreboard_pkg::*;
#(
  parameter int PENDINGWIDTH = DEFAULT_PENDINGWIDTH
) (
  input  logic       clk,
  input  logic       clk_en,
  input  logic       sync_rst,
  input  logic       accept,
  input  logic       to_runahead,
  input  logic       from_runahead,
  input  logic       dirty_issue,
  input  logic [1:0] rd_count,
  input  logic       wr,
  input  logic       dw,
  output gpr_state_t state,
  output logic       clamp
);

  logic [PENDINGWIDTH-1:0] count;
  logic [PENDINGWIDTH-1:0] count_next;
  logic [PENDINGWIDTH-1:0] rd_narrow;
  logic [PENDINGWIDTH:0]   sum;
  gpr_state_t              state_next;

  assign rd_narrow = PENDINGWIDTH'(rd_count);
  assign sum       = {1'b0, count} + {1'b0, rd_narrow};

  // Counter update: runahead diversions add the reads, runahead issues
  // retire them. Out-of-range results clamp and raise a one-cycle flag.
  always_comb begin
    count_next = count;
    clamp      = 1'b0;
    if (accept && to_runahead) begin
      if (sum[PENDINGWIDTH]) begin
        count_next = '1;
        clamp      = 1'b1;
      end else begin
        count_next = sum[PENDINGWIDTH-1:0];
      end
    end else if (accept && from_runahead) begin
      if (count < rd_narrow) begin
        count_next = '0;
        clamp      = 1'b1;
      end else begin
        count_next = count - rd_narrow;
      end
    end
  end

  // State transitions. Read effects land in count_next first, so a write
  // to a register the same instruction reads sees the updated count.
  always_comb begin
    state_next = state;
    unique case (state)
      GPR_CLEAN: begin
        if (accept && wr && dirty_issue)
          state_next = GPR_DIRTY;
        else if (accept && (rd_count != 2'd0) && to_runahead)
          state_next = GPR_SOILED;
      end
      GPR_DIRTY: begin
        if (dw && accept && wr && dirty_issue)
          state_next = GPR_DIRTY;
        else if (dw)
          state_next = GPR_CLEAN;
        else if (accept && wr && !dirty_issue)
          state_next = GPR_PENDWR;
      end
      GPR_SOILED: begin
        if (accept && wr && to_runahead)
          state_next = GPR_PENDWR;
        else if (accept && from_runahead && (count_next == '0))
          state_next = GPR_CLEAN;
      end
      GPR_PENDWR: begin
        if (dw)
          state_next = (count_next == '0) ? GPR_CLEAN : GPR_SOILED;
      end
      default: state_next = GPR_CLEAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= GPR_CLEAN;
      count <= '0;
    end else if (clk_en) begin
      state <= state_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/gpr_scoreboard_bank.sv
// gpr_scoreboard_bank
//   Scoreboard for REGCOUNT GPRs beside the register file at issue.
//   Ports:
//     clk, clk_en, sync_rst        clock, global enable, synchronous reset
//     InstructionValid             an instruction is issuing
//     ReadEnA/B, ReadAddrA/B       operand reads
//     WriteEn, WriteAddr           destination
//     DirtyIssue                   multicycle instruction
//     ToRunahead, FromRunahead     runahead queue diversion / issue
//     DirtyWriteValid/Addr         multicycle writeback
//     Stall                        combinational issue stall
//     IsClean/IsDirty/IsSoiled/HasPendingWrite  per-register state vectors
//     CounterError                 sticky counter clamp indication
module gpr_scoreboard_bank
  import gpr_scoreboard_pkg::*;
#(
  parameter int REGCOUNT     = DEFAULT_REGCOUNT,
  parameter int ADDRWIDTH    = DEFAULT_ADDRWIDTH,
  parameter int PENDINGWIDTH = DEFAULT_PENDINGWIDTH
) (
  input  logic                 clk,
  input  logic                 clk_en,
  input  logic                 sync_rst,
  input  logic                 InstructionValid,
  input  logic                 ReadEnA,
  input  logic                 ReadEnB,
  input  logic [ADDRWIDTH-1:0] ReadAddrA,
  input  logic [ADDRWIDTH-1:0] ReadAddrB,
  input  logic                 WriteEn,
  input  logic [ADDRWIDTH-1:0] WriteAddr,
  input  logic                 DirtyIssue,
  input  logic                 ToRunahead,
  input  logic                 FromRunahead,
  input  logic                 DirtyWriteValid,
  input  logic [ADDRWIDTH-1:0] DirtyWriteAddr,
  output logic                 Stall,
  output logic [REGCOUNT-1:0]  IsClean,
  output logic [REGCOUNT-1:0]  IsDirty,
  output logic [REGCOUNT-1:0]  IsSoiled,
  output logic [REGCOUNT-1:0]  HasPendingWrite,
  output logic                 CounterError
);

  logic [REGCOUNT-1:0] pend_vec;
  logic [REGCOUNT-1:0] clamp_vec;
  logic                accept;

  // Any operand or the destination touching a register still waiting on
  // its final write blocks the whole instruction.
  assign Stall = InstructionValid &
                 ((ReadEnA & pend_vec[ReadAddrA]) |
                  (ReadEnB & pend_vec[ReadAddrB]) |
                  (WriteEn & pend_vec[WriteAddr]));

  assign accept = clk_en & InstructionValid & ~Stall;

  for (genvar r = 0; r < REGCOUNT; r++) begin : g_reg
    localparam logic [ADDRWIDTH-1:0] IDX = ADDRWIDTH'(r);

    logic       hit_a;
    logic       hit_b;
    logic [1:0] rd_count;
    gpr_state_t state;

    assign hit_a    = ReadEnA & (ReadAddrA == IDX);
    assign hit_b    = ReadEnB & (ReadAddrB == IDX);
    assign rd_count = {1'b0, hit_a} + {1'b0, hit_b};

    gpr_state_cell #(
      .PENDINGWIDTH(PENDINGWIDTH)
    ) u_cell (
      .clk          (clk),
      .clk_en       (clk_en),
      .sync_rst     (sync_rst),
      .accept       (accept),
      .to_runahead  (ToRunahead),
      .from_runahead(FromRunahead),
      .dirty_issue  (DirtyIssue),
      .rd_count     (rd_count),
      .wr           (WriteEn & (WriteAddr == IDX)),
      .dw           (DirtyWriteValid & (DirtyWriteAddr == IDX)),
      .state        (state),
      .clamp        (clamp_vec[r])
    );

    assign IsClean[r]  = (state == GPR_CLEAN);
    assign IsDirty[r]  = (state == GPR_DIRTY);
    assign IsSoiled[r] = (state == GPR_SOILED);
    assign pend_vec[r] = (state == GPR_PENDWR);
  end

  assign HasPendingWrite = pend_vec;

  // Sticky error: once any counter clamps it stays up until reset.
  always_ff @(posedge clk) begin
    if (sync_rst)
      CounterError <= 1'b0;
    else if (clk_en && (|clamp_vec))
      CounterError <= 1'b1;
  end

endmodule

// File: tb/tb_gpr_scoreboard_bank.sv
// tb_gpr_scoreboard_bank
//   Drives directed and random issue/writeback traffic into a 16-register
//   scoreboard with 2-bit counters. A reference model predicts what the
//   outputs should show each cycle; a separate monitor compares them.
module tb_gpr_scoreboard_bank;

  localparam int RC   = 16;
  localparam int AW   = 4;
  localparam int PW   = 2;
  localparam int MAXC = (1 << PW) - 1;

  typedef struct {
    bit iv, ea, eb, we, di, tr, fr, dwv, en, rst;
    int a, b, w, dwa;
  } stim_t;

  typedef struct {
    logic        stall;
    logic [15:0] clean, dirty, soiled, pend;
    logic        err;
  } exp_t;

  typedef enum int {M_CLEAN, M_DIRTY, M_SOILED, M_PEND} mstate_t;

  logic          clk = 1'b0;
  logic          clk_en, sync_rst, InstructionValid, ReadEnA, ReadEnB;
  logic [AW-1:0] ReadAddrA, ReadAddrB, WriteAddr, DirtyWriteAddr;
  logic          WriteEn, DirtyIssue, ToRunahead, FromRunahead, DirtyWriteValid;
  logic          Stall, CounterError;
  logic [RC-1:0] IsClean, IsDirty, IsSoiled, HasPendingWrite;

  exp_t    exp_q[$];
  mstate_t m_state[RC];
  int      m_cnt[RC];
  bit      m_err;
  int      tests = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  gpr_scoreboard_bank #(
    .REGCOUNT(RC), .ADDRWIDTH(AW), .PENDINGWIDTH(PW)
  ) dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .InstructionValid(InstructionValid),
    .ReadEnA(ReadEnA), .ReadEnB(ReadEnB),
    .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
    .WriteEn(WriteEn), .WriteAddr(WriteAddr),
    .DirtyIssue(DirtyIssue), .ToRunahead(ToRunahead), .FromRunahead(FromRunahead),
    .DirtyWriteValid(DirtyWriteValid), .DirtyWriteAddr(DirtyWriteAddr),
    .Stall(Stall), .IsClean(IsClean), .IsDirty(IsDirty), .IsSoiled(IsSoiled),
    .HasPendingWrite(HasPendingWrite), .CounterError(CounterError)
  );

  // Reference model: registers as abstract states plus integer counts.
  function automatic void model_reset();
    for (int r = 0; r < RC; r++) begin
      m_state[r] = M_CLEAN;
      m_cnt[r]   = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit model_stall(stim_t s);
    return s.iv && ((s.ea && m_state[s.a] == M_PEND) ||
                    (s.eb && m_state[s.b] == M_PEND) ||
                    (s.we && m_state[s.w] == M_PEND));
  endfunction

  function automatic exp_t model_view(stim_t s);
    exp_t e;
    e.stall = model_stall(s);
    for (int r = 0; r < RC; r++) begin
      e.clean[r]  = (m_state[r] == M_CLEAN);
      e.dirty[r]  = (m_state[r] == M_DIRTY);
      e.soiled[r] = (m_state[r] == M_SOILED);
      e.pend[r]   = (m_state[r] == M_PEND);
    end
    e.err = m_err;
    return e;
  endfunction

  function automatic void model_step(stim_t s);
    bit acc;
    if (s.rst) begin
      model_reset();
      return;
    end
    if (!s.en) return;
    acc = s.iv && !model_stall(s);
    for (int r = 0; r < RC; r++) begin
      int rd, n;
      bit wr, dw;
      rd = int'(s.ea && s.a == r) + int'(s.eb && s.b == r);
      wr = s.we && s.w == r;
      dw = s.dwv && s.dwa == r;
      n  = m_cnt[r];
      if (acc && s.tr) begin
        n = n + rd;
        if (n > MAXC) begin n = MAXC; m_err = 1'b1; end
      end else if (acc && s.fr) begin
        n = n - rd;
        if (n < 0) begin n = 0; m_err = 1'b1; end
      end
      case (m_state[r])
        M_CLEAN:
          if (acc && wr && s.di) m_state[r] = M_DIRTY;
          else if (acc && rd > 0 && s.tr) m_state[r] = M_SOILED;
        M_DIRTY:
          if (dw && acc && wr && s.di) m_state[r] = M_DIRTY;
          else if (dw) m_state[r] = M_CLEAN;
          else if (acc && wr && !s.di) m_state[r] = M_PEND;
        M_SOILED:
          if (acc && wr && s.tr) m_state[r] = M_PEND;
          else if (acc && s.fr && n == 0) m_state[r] = M_CLEAN;
        default:
          if (dw) m_state[r] = (n == 0) ? M_CLEAN : M_SOILED;
      endcase
      m_cnt[r] = n;
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.en = 1'b1;
    return s;
  endfunction

  function automatic int pick_addr();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, RC - 1));
  endfunction

  // Drive one cycle, record what the DUT should show during it, advance model.
  task automatic applyStimulus(input stim_t s);
    clk_en           = s.en;
    sync_rst         = s.rst;
    InstructionValid = s.iv;
    ReadEnA          = s.ea;
    ReadEnB          = s.eb;
    ReadAddrA        = s.a[AW-1:0];
    ReadAddrB        = s.b[AW-1:0];
    WriteEn          = s.we;
    WriteAddr        = s.w[AW-1:0];
    DirtyIssue       = s.di;
    ToRunahead       = s.tr;
    FromRunahead     = s.fr;
    DirtyWriteValid  = s.dwv;
    DirtyWriteAddr   = s.dwa[AW-1:0];
    exp_q.push_back(model_view(s));
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic check_one(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check_one("stall",  {15'b0, Stall},        {15'b0, e.stall});
    check_one("clean",  IsClean,               e.clean);
    check_one("dirty",  IsDirty,               e.dirty);
    check_one("soiled", IsSoiled,              e.soiled);
    check_one("pendwr", HasPendingWrite,       e.pend);
    check_one("cnterr", {15'b0, CounterError}, {15'b0, e.err});
  endtask

  // Monitor: compares every cycle that has a prediction waiting.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    stim_t s;

    s = idle();
    s.rst = 1'b1;
    s.en  = 1'b0;
    clk_en = 1'b0; sync_rst = 1'b1; InstructionValid = 1'b0;
    ReadEnA = 1'b0; ReadEnB = 1'b0; ReadAddrA = '0; ReadAddrB = '0;
    WriteEn = 1'b0; WriteAddr = '0; DirtyIssue = 1'b0; ToRunahead = 1'b0;
    FromRunahead = 1'b0; DirtyWriteValid = 1'b0; DirtyWriteAddr = '0;
    model_reset();
    @(posedge clk);
    #1;
    $display("[TB] reset released, directed sequence");

    applyStimulus(idle());
    // r3: multicycle write then writeback
    s = idle(); s.iv = 1; s.we = 1; s.w = 3; s.di = 1; applyStimulus(s);
    s = idle(); s.dwv = 1; s.dwa = 3; applyStimulus(s);
    applyStimulus(idle());
    // r5: double runahead read, then two single retirements
    s = idle(); s.iv = 1; s.tr = 1; s.ea = 1; s.a = 5; s.eb = 1; s.b = 5; applyStimulus(s);
    s = idle(); s.iv = 1; s.fr = 1; s.ea = 1; s.a = 5; applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());
    // r7: Dirty, plain write -> PendingWrite, stalled read, writeback
    s = idle(); s.iv = 1; s.we = 1; s.w = 7; s.di = 1; applyStimulus(s);
    s = idle(); s.iv = 1; s.we = 1; s.w = 7; applyStimulus(s);
    s = idle(); s.iv = 1; s.ea = 1; s.a = 7; applyStimulus(s);
    s.dwv = 1; s.dwa = 7; applyStimulus(s);
    s = idle(); s.iv = 1; s.ea = 1; s.a = 7; applyStimulus(s);
    // r1: saturate the 2-bit counter, error must stick
    s = idle(); s.iv = 1; s.tr = 1; s.ea = 1; s.a = 1;
    for (int i = 0; i < 4; i++) applyStimulus(s);
    for (int i = 0; i < 3; i++) applyStimulus(idle());
    // r2 Soiled, reset with clk_en low, then prove its counter restarted at 0
    s = idle(); s.iv = 1; s.tr = 1; s.ea = 1; s.a = 2; applyStimulus(s);
    s = idle(); s.rst = 1; s.en = 0; applyStimulus(s);
    applyStimulus(idle());
    s = idle(); s.iv = 1; s.tr = 1; s.ea = 1; s.a = 2; applyStimulus(s);
    s = idle(); s.iv = 1; s.fr = 1; s.ea = 1; s.a = 2; applyStimulus(s);
    applyStimulus(idle());

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      int mode;
      s = idle();
      s.en  = ($urandom_range(0, 9) != 0);
      s.rst = ($urandom_range(0, 299) == 0);
      s.iv  = ($urandom_range(0, 9) < 7);
      s.ea  = $urandom_range(0, 1);
      s.eb  = $urandom_range(0, 1);
      s.we  = $urandom_range(0, 1);
      s.di  = $urandom_range(0, 1);
      mode  = int'($urandom_range(0, 2));
      s.tr  = (mode == 1);
      s.fr  = (mode == 2);
      s.dwv = ($urandom_range(0, 9) < 4);
      s.a   = pick_addr();
      s.b   = pick_addr();
      s.w   = pick_addr();
      s.dwa = pick_addr();
      applyStimulus(s);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain: got %0d predictions left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
